// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input sync, 2-of-3 majority vote around mid-bit, valid/ready byte output.
// valid rises 1 clk after the stop-bit decision; an unconsumed byte causes the new one to drop with an overrun pulse.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_pulse,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_V0   = CW'(M - 1);
  localparam logic [CW-1:0] CNT_V1   = CW'(M);
  localparam logic [CW-1:0] CNT_DEC  = CW'(M + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          v0_q, v0_d, v1_q, v1_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          decide, vote;

  assign decide = sample_pulse && (cnt_q == CNT_DEC);
  assign vote   = (v0_q & v1_q) | (v0_q & rx_s_q) | (v1_q & rx_s_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      v0_q      <= 1'b1;
      v1_q      <= 1'b1;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    v0_d      = v0_q;
    v1_d      = v1_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    if (sample_pulse) begin
      if (state_q != IDLE) begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        if (cnt_q == CNT_V0) v0_d = rx_s_q;
        if (cnt_q == CNT_V1) v1_d = rx_s_q;
      end
      unique case (state_q)
        IDLE: begin
          // A line that never went high since the last error cannot start a frame.
          if (rx_s_q) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = START;
            cnt_d   = CW'(1);
            armed_d = 1'b0;
          end
        end
        START: begin
          if (decide) begin
            if (vote) begin
              state_d = IDLE;
              cnt_d   = '0;
              armed_d = 1'b1;
            end else begin
              state_d   = DATA;
              bit_idx_d = 3'd0;
            end
          end
        end
        DATA: begin
          if (decide) begin
            shift_d   = {vote, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = STOP;
          end
        end
        STOP: begin
          // Leave mid-stop-bit so the next start edge is caught promptly.
          if (decide) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = vote;
            ferr_d  = ~vote;
          end
        end
      endcase
    end
  end

  always_comb begin
    byte_d  = byte_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && ready) valid_d = 1'b0;
    if (done_q) begin
      if (!valid_q || ready) begin
        byte_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_comb begin
    byte_out  = byte_q;
    valid     = valid_q;
    frame_err = ferr_q;
    overrun   = ovr_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames from the test plan plus randomized traffic, checked each cycle against a frame-level model.
module tb_uart_rx;
  localparam int OS = 16;
  localparam int M  = OS / 2;

  logic       clk = 1'b0;
  logic       rst_n, sample_pulse, rx, ready;
  logic [7:0] byte_out;
  logic       valid, frame_err, overrun;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .sample_pulse(sample_pulse), .rx(rx),
    .byte_out(byte_out), .valid(valid), .ready(ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int per = 4;
  bit rnd_ready = 0;

  // model outputs
  logic       m_valid, m_ferr, m_ovr, m_cpend;
  logic [7:0] m_byte, m_shift;
  logic       d0, d1;

  int         n_valid_rise = 0, n_ferr = 0, n_ovr = 0;
  logic [7:0] last_byte = 8'h00;
  logic       prev_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_byte = 8'h00; m_ferr = 0; m_ovr = 0; m_cpend = 0;
    d0 = 1; d1 = 1;
  endtask

  // One clock of the model: synchronizer history plus output/handshake rules.
  task automatic model_edge(output logic s, output bit sp, output bit ab);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      s = 1; sp = 0; ab = 1;
      return;
    end
    ab = 0;
    sp = sample_pulse;
    s  = d1;
    d1 = d0;
    d0 = rx;
    m_ferr = 0;
    m_ovr  = 0;
    if (m_cpend) begin
      if (!m_valid || ready) begin
        m_byte  = m_shift;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && ready) begin
      m_valid = 0;
    end
    m_cpend = 0;
  endtask

  task automatic next_pulse(output logic s, output bit ab);
    bit sp;
    do model_edge(s, sp, ab); while (!ab && !sp);
  endtask

  // Frame-level model: pulse k after the start detection sees sample index k mod OS.
  initial begin : model
    logic s, vote;
    logic v0, v1;
    bit   ab, armed, started, glitch;
    int   b, ph;
    model_reset();
    armed = 0;
    v0 = 1; v1 = 1;
    forever begin
      started = 0;
      while (!started) begin
        next_pulse(s, ab);
        if (ab) armed = 0;
        else if (s) armed = 1;
        else if (armed) begin
          started = 1;
          armed = 0;
        end
      end
      glitch = 0;
      ab = 0;
      for (int i = 1; i <= 9 * OS + M + 1; i++) begin
        next_pulse(s, ab);
        if (ab) break;
        ph = i % OS;
        b  = i / OS;
        if (ph == M - 1) v0 = s;
        else if (ph == M) v1 = s;
        else if (ph == M + 1) begin
          vote = ((int'(v0) + int'(v1) + int'(s)) >= 2);
          if (b == 0) begin
            if (vote) begin
              glitch = 1;
              break;
            end
          end else if (b <= 8) begin
            m_shift[b-1] = vote;
          end else begin
            if (vote) m_cpend = 1;
            else m_ferr = 1;
          end
        end
      end
      armed = glitch && !ab;
    end
  end

  // Compare process plus event counters used by the directed checks.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_byte_out", byte_out, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
      end else begin
        chk("byte_out", byte_out, m_byte);
        chk("valid", valid, m_valid);
        chk("frame_err", frame_err, m_ferr);
        chk("overrun", overrun, m_ovr);
        chk("err_exclusive", frame_err & overrun, 0);
      end
      if (valid && !prev_valid) n_valid_rise++;
      if (valid) last_byte = byte_out;
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      prev_valid = valid;
    end
  end

  initial begin : pulse_gen
    int pc;
    pc = 0;
    sample_pulse = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sample_pulse = (pc == 0);
      pc = (pc + 1 >= per) ? 0 : pc + 1;
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int glitch_bit);
    int bc;
    bc = OS * per;
    rx = 1'b0;
    tick(bc);
    for (int k = 0; k < 8; k++) begin
      rx = d[k];
      if (k == glitch_bit) begin
        tick(bc / 2);
        rx = ~d[k];
        tick(per);
        rx = d[k];
        tick(bc - bc / 2 - per);
      end else begin
        tick(bc);
      end
    end
    rx = stop_bit;
    tick(bc);
  endtask

  initial begin : stim
    int base_v, base_f, base_o, bc;
    bit found;
    logic [7:0] d;
    bit bad;
    int g;
    rst_n = 1'b1; rx = 1'b1; ready = 1'b1;
    #1 rst_n = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(20);
    bc = OS * per;

    // normal byte
    base_v = n_valid_rise;
    send_frame(8'hA5, 1'b1, -1);
    tick(8);
    chk("a5_valid_pulses", n_valid_rise - base_v, 1);
    chk("a5_byte", last_byte, 8'hA5);
    chk("a5_no_err", n_ferr + n_ovr, 0);

    // false start, then a real frame
    base_v = n_valid_rise;
    rx = 1'b0; tick(5 * per); rx = 1'b1; tick(2 * bc);
    chk("glitch_no_valid", n_valid_rise - base_v, 0);
    send_frame(8'h3C, 1'b1, -1);
    tick(8);
    chk("3c_byte", last_byte, 8'h3C);
    chk("3c_valid_pulses", n_valid_rise - base_v, 1);

    // single-sample noise inside bit 3
    send_frame(8'h00, 1'b1, 3);
    tick(8);
    chk("noise_byte", last_byte, 8'h00);
    chk("noise_valid_pulses", n_valid_rise - base_v, 2);

    // framing error followed by a break
    base_v = n_valid_rise; base_f = n_ferr;
    send_frame(8'h7E, 1'b0, -1);
    tick(3 * bc);
    chk("break_ferr_pulses", n_ferr - base_f, 1);
    chk("break_no_valid", n_valid_rise - base_v, 0);
    rx = 1'b1; tick(bc);
    send_frame(8'h81, 1'b1, -1);
    tick(8);
    chk("81_byte", last_byte, 8'h81);

    // overrun with ready held low
    ready = 1'b0; base_o = n_ovr;
    send_frame(8'h12, 1'b1, -1);
    send_frame(8'h34, 1'b1, -1);
    tick(8);
    chk("ovr_valid", valid, 1);
    chk("ovr_byte", byte_out, 8'h12);
    chk("ovr_pulses", n_ovr - base_o, 1);
    ready = 1'b1; tick(1); ready = 1'b0;
    chk("consume_valid", valid, 0);

    // ready exactly on the completion clk replaces the byte
    send_frame(8'h12, 1'b1, -1);
    base_o = n_ovr;
    found = 0;
    fork
      send_frame(8'h34, 1'b1, -1);
      begin
        for (int k = 0; k < 12 * bc && !found; k++) begin
          @(posedge clk); #1;
          if (m_cpend) begin
            ready = 1'b1;
            @(posedge clk); #1;
            ready = 1'b0;
            found = 1;
          end
        end
      end
    join
    tick(8);
    chk("swap_seen", found, 1);
    chk("swap_byte", byte_out, 8'h34);
    chk("swap_valid", valid, 1);
    chk("swap_no_ovr", n_ovr - base_o, 0);
    ready = 1'b1; tick(2);

    // reset during bit 4 of 0xFF
    rx = 1'b0; tick(bc);
    for (int k = 0; k < 4; k++) begin rx = 1'b1; tick(bc); end
    tick(bc / 2);
    rst_n = 1'b0;
    tick(3);
    chk("midrst_valid", valid, 0);
    chk("midrst_byte", byte_out, 8'h00);
    rx = 1'b1; rst_n = 1'b1;
    tick(2 * bc);
    base_v = n_valid_rise;
    send_frame(8'h5A, 1'b1, -1);
    tick(8);
    chk("5a_byte", last_byte, 8'h5A);
    chk("5a_valid_pulses", n_valid_rise - base_v, 1);

    // randomized traffic
    rnd_ready = 1;
    for (int f = 0; f < 30; f++) begin
      per = $urandom_range(1, 4);
      tick(2 * OS * per);
      d   = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      g   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
      send_frame(d, !bad, g);
      rx = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        rx = 1'b0;
        tick($urandom_range(1, 6) * per);
        rx = 1'b1;
      end
    end
    rnd_ready = 0;
    ready = 1'b1;
    tick(4 * OS * 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; serial-to-parallel counterpart of the board's uart_tx.
- Samples the asynchronous rx line at OVERSAMPLE× the baud rate, using a shared strobe from the baud generator.
- Fixed frame: 8N1, LSB first.
- Presents each received byte to downstream logic through a valid/ready handshake.
- Reports framing errors and overruns as 1-cycle pulses.

Parameters:
- OVERSAMPLE, 16, sample_pulse strobes per bit period; even, >= 8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- sample_pulse  in  1  1-clk strobe at OVERSAMPLE×baud
- rx  in  1  asynchronous serial input; idle high
- byte_out  out  8  received byte; stable while valid=1
- valid  out  1  byte_out holds an unconsumed byte
- ready  in  1  consumer accepts byte when valid&&ready
- frame_err  out  1  1-clk pulse: stop bit sampled low
- overrun  out  1  1-clk pulse: completed byte dropped because previous one unconsumed

Behaviour:
- Reset values:
  - byte_out=0x00, valid=0, frame_err=0, overrun=0.
  - Synchronizer FFs=1, state=IDLE, sample counter=0, armed=0.
  - Reset mid-frame aborts the frame with no pulses; nothing is retained.
- Input sync:
  - rx passes through a 2-FF synchronizer → rx_s.
  - All decisions use rx_s, evaluated only on clk edges where sample_pulse=1.
- Sample counter cnt:
  - 0..OVERSAMPLE-1, advances on sample_pulse and wraps to 0.
  - M = OVERSAMPLE/2.
- Majority vote: a bit value is the 2-of-3 majority of rx_s samples at cnt=M-1, M, M+1; the decision is taken at cnt=M+1.
- IDLE:
  - armed is set when rx_s=1 is seen on a sample_pulse.
  - If armed and rx_s=0 on a sample_pulse: go to START, set cnt=1, clear armed.
  - If not armed, low is ignored; a break does not retrigger.
- START:
  - At the decision point, vote=1 (false start / glitch): return to IDLE with armed=1; no outputs change.
  - vote=0: go to DATA, cnt continues and wraps, bit index=0.
- DATA:
  - At each decision, the vote is shifted into bit[index], LSB first.
  - After index 7, go to STOP.
- STOP: at the decision, go to IDLE immediately, mid-stop-bit, to allow resync.
  - vote=1: byte complete. The next clk applies the output rules below.
  - vote=0: frame_err=1 for exactly 1 clk; byte discarded; armed=0, so the line must return high before the next start.
- Output rules, evaluated on the clk after a byte completes:
  - valid=0: load byte_out, valid←1.
  - valid=1 and ready=1 in that same cycle: consumed byte retired, new byte loaded, valid stays 1, no overrun.
  - valid=1 and ready=0: new byte dropped, byte_out unchanged, overrun=1 for 1 clk.
- Handshake:
  - Transfer occurs on a clk edge with valid&&ready; valid←0 on the next edge unless a new byte loads simultaneously.
  - ready is ignored when valid=0.
- Latency: valid rises 1 clk after the stop-bit decision edge.
- Frame timing: start falling edge to valid ≈ 9.5 bit periods + 2-FF sync + 1 clk.
- sample_pulse held high continuously is legal; then OVERSAMPLE clks = 1 bit.
- frame_err and overrun never assert in the same cycle.

Test Plan:
- Normal byte: OVERSAMPLE=16, sample_pulse every 4 clk, ready=1; send 0xA5 (8N1, 64 clk/bit) → valid 1 clk, byte_out=0xA5, no error pulses.
- Glitch start: rx low for 5 sample_pulses then high → no valid, state back to IDLE; a following frame 0x3C is received correctly.
- Noise immunity: send 0x00 with rx forced high for exactly 1 sample_pulse at cnt=M inside bit 3 → byte_out=0x00.
- Framing/break: send 0x7E with stop bit low, then hold rx low for 3 bit periods → one frame_err pulse, valid stays 0, no retrigger; after rx returns high, 0x81 is received.
- Overrun and handshake:
  - ready=0; send 0x12 then 0x34 back-to-back → valid=1, byte_out=0x12, one overrun pulse.
  - Then ready=1 for 1 clk → valid=0.
  - Repeat with ready=1 exactly on the completion clk of 0x34 → byte_out=0x34, valid stays 1, no overrun.
- Reset mid-frame: assert rst_n=0 during bit 4 of 0xFF → all outputs return to reset values; after release with rx high, 0x5A is received correctly.
